// File: rtl/alu_op_sequencer_if.sv
// Bundle between the calculator controller, the sequencer and the combinational ALU.
// The slave side is the sequencer; the master side is everything around it.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic             clear_err;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_binvert;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry_out;
  logic             alu_overflow;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err_sticky;

  modport master (
    output start, op_a, op_b, op_sel, clear_err,
    output alu_result, alu_carry_out, alu_overflow,
    input  alu_a, alu_b, alu_binvert, alu_op,
    input  busy, done, result, flag_z, flag_n, flag_c, flag_v, err_sticky
  );

  modport slave (
    input  start, op_a, op_b, op_sel, clear_err,
    input  alu_result, alu_carry_out, alu_overflow,
    output alu_a, alu_b, alu_binvert, alu_op,
    output busy, done, result, flag_z, flag_n, flag_c, flag_v, err_sticky
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for a combinational ALU: latches operands on start, holds
// them for SETTLE_CYCLES, then registers result, flags and a sticky overflow error.
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  alu_op_sequencer_if.slave bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   load;
  logic   capture;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_binvert_q;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_z_q;
  logic             flag_n_q;
  logic             flag_c_q;
  logic             flag_v_q;
  logic             err_q;
  logic             arith;
  logic             cap_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= '0;
    else if (state == SETTLE) cnt <= cnt + 1'b1;
  end

  // ALU inputs stay stable through SETTLE and hold until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_binvert_q <= 1'b0;
    end else if (load) begin
      alu_a_q       <= bus.op_a;
      alu_b_q       <= bus.op_b;
      alu_op_q      <= bus.op_sel;
      alu_binvert_q <= (bus.op_sel == 2'b01);
    end
  end

  // Logic ops (op[1]=1) mask carry/overflow regardless of what the ALU reports.
  assign arith   = ~alu_op_q[1];
  assign cap_ovf = arith & bus.alu_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (capture) begin
      result_q <= bus.alu_result;
      flag_z_q <= (bus.alu_result == '0);
      flag_n_q <= bus.alu_result[WIDTH-1];
      flag_c_q <= arith & bus.alu_carry_out;
      flag_v_q <= cap_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     err_q <= 1'b0;
    else if (capture && cap_ovf) err_q <= 1'b1;
    else if (bus.clear_err)      err_q <= 1'b0;
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_binvert = alu_binvert_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.busy        = (state == SETTLE);
  assign bus.done        = (state == DONE);
  assign bus.result      = result_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_n      = flag_n_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_v      = flag_v_q;
  assign bus.err_sticky  = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer with a behavioural ALU and
// an arithmetic reference model of the expected result, flags and sticky error.
module tb_alu_op_sequencer;
  localparam int W = 8;
  localparam int S = 1;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_cv = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   exp_err = 0;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ripple-style ALU: B optionally inverted, binvert used as carry-in.
  logic [W-1:0] bb;
  logic [W:0]   sum;
  always_comb begin
    bb  = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
    sum = {1'b0, bus.alu_a} + {1'b0, bb} + {{W{1'b0}}, bus.alu_binvert};
    case (bus.alu_op)
      2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
      2'b11:   bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = sum[W-1:0];
    endcase
    bus.alu_carry_out = sum[W] | force_cv;
    bus.alu_overflow  = ((bus.alu_a[W-1] == bb[W-1]) && (sum[W-1] != bus.alu_a[W-1])) | force_cv;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Expected outcome from plain integer arithmetic on the operation's meaning.
  function automatic void ref_op(input int a, input int b, input int sel,
                                 output int r, output int c, output int v);
    int t;
    int sv;
    r = 0; c = 0; v = 0;
    case (sel)
      0: begin
        t  = a + b;
        r  = t % M;
        c  = (t >= M) ? 1 : 0;
        sv = to_signed(a) + to_signed(b);
        v  = (sv >= M / 2 || sv < -(M / 2)) ? 1 : 0;
      end
      1: begin
        t  = a - b;
        r  = (t + M) % M;
        c  = (a >= b) ? 1 : 0;
        sv = to_signed(a) - to_signed(b);
        v  = (sv >= M / 2 || sv < -(M / 2)) ? 1 : 0;
      end
      2: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    check_eq({tag, ".done"},   32'(bus.done), 0);
    check_eq({tag, ".busy"},   32'(bus.busy), 0);
    check_eq({tag, ".result"}, 32'(bus.result), 0);
    check_eq({tag, ".flags"},  32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 0);
    check_eq({tag, ".err"},    32'(bus.err_sticky), 0);
    check_eq({tag, ".alu_in"}, 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_binvert}), 0);
  endtask

  // Issue one operation from a negedge; optionally assert clear_err on the capture
  // edge, or keep start asserted with other operands while the op is in flight.
  task automatic run_op(input int a, input int b, input int sel, input bit clr, input bit spam);
    int r, c, v, n;
    bit got;
    ref_op(a, b, sel, r, c, v);
    if (sel >= 2) begin c = 0; v = 0; end
    bus.op_a = W'(a); bus.op_b = W'(b); bus.op_sel = 2'(sel);
    bus.start = 1'b1; bus.clear_err = 1'b0;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check_eq("busy", 32'(bus.busy), 1);
      if (bus.done) begin got = 1'b1; break; end
      bus.start     = spam;
      bus.op_a      = W'($urandom);
      bus.op_b      = W'($urandom);
      bus.op_sel    = 2'($urandom);
      bus.clear_err = clr && (n == S);
    end
    bus.clear_err = 1'b0;
    if (v != 0) exp_err = 1;
    else if (clr) exp_err = 0;
    check_eq("done_seen", 32'(got), 1);
    check_eq("latency", n, S + 1);
    check_eq("busy_at_done", 32'(bus.busy), 0);
    check_eq("result", 32'(bus.result), r);
    check_eq("flag_z", 32'(bus.flag_z), (r == 0) ? 1 : 0);
    check_eq("flag_n", 32'(bus.flag_n), (r >> (W - 1)) & 1);
    check_eq("flag_c", 32'(bus.flag_c), c);
    check_eq("flag_v", 32'(bus.flag_v), v);
    check_eq("err", 32'(bus.err_sticky), exp_err);
    check_eq("alu_a_hold", 32'(bus.alu_a), a);
    check_eq("alu_b_hold", 32'(bus.alu_b), b);
    check_eq("alu_op_hold", 32'({bus.alu_op, bus.alu_binvert}), (sel << 1) | ((sel == 1) ? 1 : 0));
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_pulse", 32'(bus.done), 0);
    if (spam) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_eq("spam_no_done", 32'(bus.done), 0);
        check_eq("spam_hold", 32'(bus.result), r);
      end
    end
  endtask

  task automatic idle_cycles(input int cnt, input bit rnd_clear);
    for (int i = 0; i < cnt; i++) begin
      bus.clear_err = rnd_clear ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (bus.clear_err) exp_err = 0;
      check_eq("idle_err", 32'(bus.err_sticky), exp_err);
      check_eq("idle_done", 32'(bus.done), 0);
    end
    bus.clear_err = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = '0; bus.clear_err = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h7F, 8'h01, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1, 1'b0, 1'b0);
    run_op(8'h05, 8'h05, 1, 1'b0, 1'b0);
    force_cv = 1'b1;
    run_op(8'hF0, 8'h0F, 2, 1'b0, 1'b0);
    force_cv = 1'b0;
    run_op(8'h12, 8'h34, 3, 1'b0, 1'b1);

    idle_cycles(1, 1'b0);
    bus.clear_err = 1'b1;
    @(negedge clk);
    exp_err = 0;
    bus.clear_err = 1'b0;
    check_eq("clear_alone", 32'(bus.err_sticky), 0);
    run_op(8'h40, 8'h40, 0, 1'b1, 1'b0);
    bus.clear_err = 1'b1;
    @(negedge clk);
    exp_err = 0;
    bus.clear_err = 1'b0;
    check_eq("clear_after_set", 32'(bus.err_sticky), 0);

    run_op(8'h7F, 8'h7F, 0, 1'b0, 1'b0);
    bus.op_a = 8'h11; bus.op_b = 8'h22; bus.op_sel = 2'b00; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("pre_reset_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_no_done", 32'(bus.done), 0);
    end
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    check_eq("post_reset_done", 32'(bus.done), 0);
    run_op(8'h22, 8'h33, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      idle_cycles(int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
